// File: rtl/axis_trigger_frame_gate.sv
// rtl/axis_trigger_frame_gate.sv - trigger-aligned frame gate in front of the accumulating averager
module axis_trigger_frame_gate #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16,
    parameter int AVGS_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        run,
    input  logic                        trg_flag,
    input  logic [CNTR_WIDTH-1:0]       frame_len,
    input  logic [AVGS_WIDTH-1:0]       avgs_limit,
    output logic [AVGS_WIDTH-1:0]       avgs_cntr,
    output logic                        busy,
    output logic                        done,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        GATE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    run_q;
    logic                    trg_q;
    logic [CNTR_WIDTH-1:0]   frame_len_reg;
    logic [CNTR_WIDTH-1:0]   smp_cntr;
    logic [AVGS_WIDTH-1:0]   avgs_cntr_reg;
    logic [AVGS_WIDTH-1:0]   avgs_inc;
    logic                    run_rise;
    logic                    trg_rise;
    logic                    in_gate;
    logic                    xfer;
    logic                    last_beat;

    assign run_rise  = run & ~run_q;
    assign trg_rise  = trg_flag & ~trg_q;
    assign in_gate   = (state == GATE);
    assign xfer      = s_axis_tvalid & m_axis_tready & in_gate;
    assign last_beat = xfer & (smp_cntr == frame_len_reg);
    assign avgs_inc  = avgs_cntr_reg + AVGS_WIDTH'(1);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame, once opened, always runs to its last sample so the averager stays aligned.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run_rise) begin
                    state_next = (avgs_limit == '0) ? DONE : ARMED;
                end
            end
            ARMED: begin
                if (!run) begin
                    state_next = IDLE;
                end else if (trg_rise) begin
                    state_next = GATE;
                end
            end
            GATE: begin
                if (last_beat) begin
                    if (avgs_inc == avgs_limit) begin
                        state_next = DONE;
                    end else if (!run) begin
                        state_next = IDLE;
                    end else begin
                        state_next = ARMED;
                    end
                end
            end
            DONE: begin
                if (!run) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state == ARMED) || (state == GATE);
        done          = (state == DONE);
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid & in_gate;
        s_axis_tready = in_gate ? m_axis_tready : 1'b1;
        avgs_cntr     = avgs_cntr_reg;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            run_q         <= 1'b0;
            trg_q         <= 1'b0;
            frame_len_reg <= '0;
            smp_cntr      <= '0;
            avgs_cntr_reg <= '0;
        end else begin
            run_q <= run;
            trg_q <= trg_flag;
            case (state)
                IDLE: begin
                    if (run_rise) begin
                        avgs_cntr_reg <= '0;
                    end
                end
                ARMED: begin
                    if (run && trg_rise) begin
                        frame_len_reg <= frame_len;
                        smp_cntr      <= '0;
                    end
                end
                GATE: begin
                    if (last_beat) begin
                        smp_cntr      <= '0;
                        avgs_cntr_reg <= avgs_inc;
                    end else if (xfer) begin
                        smp_cntr <= smp_cntr + CNTR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_trigger_frame_gate.sv
// tb/tb_axis_trigger_frame_gate.sv - directed self-checking bench for axis_trigger_frame_gate
module tb_axis_trigger_frame_gate;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int AW = 32;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          run;
    logic          trg_flag;
    logic [CW-1:0] frame_len;
    logic [AW-1:0] avgs_limit;
    logic [AW-1:0] avgs_cntr;
    logic          busy;
    logic          done;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;

    int checks = 0;
    int passes = 0;

    // Stream source and beat bookkeeping collected by tick().
    logic [DW-1:0] src = '0;
    logic [DW-1:0] last_data;
    int cyc = 0;
    int frame_beats = 0;
    int first_cyc = -1;
    int data_err = 0;
    int tv_cnt = 0;

    always #5 aclk = ~aclk;

    axis_trigger_frame_gate #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH(CW),
        .AVGS_WIDTH(AW)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .run(run),
        .trg_flag(trg_flag),
        .frame_len(frame_len),
        .avgs_limit(avgs_limit),
        .avgs_cntr(avgs_cntr),
        .busy(busy),
        .done(done),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid)
    );

    // Inputs are set just after a rising edge; outputs sampled 1 time unit later.
    task automatic tick();
        logic consumed;
        #1;
        consumed = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid) tv_cnt++;
        if (m_axis_tvalid && m_axis_tready) begin
            if (frame_beats == 0) first_cyc = cyc;
            else if (m_axis_tdata !== last_data + 1) data_err++;
            last_data = m_axis_tdata;
            frame_beats++;
        end
        @(posedge aclk);
        #1;
        if (consumed) begin
            src = src + 1;
            s_axis_tdata = src;
        end
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_trg();
        trg_flag = 1'b1;
        tick();
        trg_flag = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; run = 1'b0; trg_flag = 1'b0;
        frame_len = 16'd7; avgs_limit = 32'd3;
        s_axis_tvalid = 1'b1; m_axis_tready = 1'b0; s_axis_tdata = src;
        ticks(3);
        aresetn = 1'b1;
        #1;
        checks++;
        if ({busy, done, m_axis_tvalid, s_axis_tready} !== 4'b0001)
            $display("FAIL reset_flags busy/done/tvalid/tready=%b want 0001", {busy, done, m_axis_tvalid, s_axis_tready});
        else passes++;
        checks++;
        if (avgs_cntr !== 32'd0) $display("FAIL reset_avgs got %0d want 0", avgs_cntr);
        else passes++;
    endtask

    task automatic test_three_frames();
        int pulse_cyc;
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1;
        frame_len = 16'd7; avgs_limit = 32'd3;
        run = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL arm_busy got %b want 1", busy);
        else passes++;
        data_err = 0;
        for (int f = 1; f <= 3; f++) begin
            frame_beats = 0;
            pulse_cyc = cyc;
            pulse_trg();
            ticks(19);
            checks++;
            if (frame_beats !== 8) $display("FAIL burst_len frame %0d got %0d want 8", f, frame_beats);
            else passes++;
            checks++;
            if (first_cyc !== pulse_cyc + 1) $display("FAIL burst_start frame %0d got cyc %0d want %0d", f, first_cyc, pulse_cyc + 1);
            else passes++;
            checks++;
            if (avgs_cntr !== AW'(f)) $display("FAIL avgs_cntr frame %0d got %0d want %0d", f, avgs_cntr, f);
            else passes++;
        end
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL three_done done/busy=%b want 10", {done, busy});
        else passes++;
        checks++;
        if (data_err !== 0) $display("FAIL three_data_order errors=%0d want 0", data_err);
        else passes++;
        run = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0) $display("FAIL done_to_idle done=%b want 0", done);
        else passes++;
    endtask

    task automatic test_trigger_held();
        frame_len = 16'd15; avgs_limit = 32'd2;
        run = 1'b1;
        tick();
        frame_beats = 0;
        trg_flag = 1'b1;
        ticks(30);
        checks++;
        if (frame_beats !== 16) $display("FAIL held_trg_beats got %0d want 16", frame_beats);
        else passes++;
        checks++;
        if ({busy, avgs_cntr} !== {1'b1, 32'd1}) $display("FAIL held_trg_state busy=%b avgs=%0d want 1/1", busy, avgs_cntr);
        else passes++;
        trg_flag = 1'b0;
        tick();
        frame_beats = 0;
        data_err = 0;
        pulse_trg();
        ticks(5);
        pulse_trg();
        ticks(20);
        checks++;
        if (frame_beats !== 16) $display("FAIL midframe_edge_beats got %0d want 16", frame_beats);
        else passes++;
        checks++;
        if ({done, avgs_cntr} !== {1'b1, 32'd2}) $display("FAIL midframe_edge_done done=%b avgs=%0d want 1/2", done, avgs_cntr);
        else passes++;
        checks++;
        if (data_err !== 0) $display("FAIL midframe_data_order errors=%0d want 0", data_err);
        else passes++;
        run = 1'b0;
        tick();
    endtask

    task automatic test_stalls();
        frame_len = 16'd4; avgs_limit = 32'd2;
        run = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            frame_beats = 0;
            data_err = 0;
            pulse_trg();
            for (int i = 0; i < 40; i++) begin
                s_axis_tvalid = (i % 2) == 1;
                m_axis_tready = (i % 3) != 2;
                if (f == 1 && i == 2) frame_len = 16'd9;
                tick();
            end
            s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
            checks++;
            if (frame_beats !== 5) $display("FAIL stall_beats frame %0d got %0d want 5", f, frame_beats);
            else passes++;
            checks++;
            if (data_err !== 0) $display("FAIL stall_data_order frame %0d errors=%0d want 0", f, data_err);
            else passes++;
        end
        checks++;
        if ({done, avgs_cntr} !== {1'b1, 32'd2}) $display("FAIL stall_done done=%b avgs=%0d want 1/2", done, avgs_cntr);
        else passes++;
        run = 1'b0;
        tick();
    endtask

    task automatic test_run_drop();
        frame_len = 16'd9; avgs_limit = 32'd5;
        run = 1'b1;
        tick();
        frame_beats = 0;
        pulse_trg();
        for (int i = 0; i < 20; i++) begin
            if (frame_beats == 3) run = 1'b0;
            tick();
        end
        checks++;
        if (frame_beats !== 10) $display("FAIL run_drop_beats got %0d want 10", frame_beats);
        else passes++;
        checks++;
        if ({busy, done, avgs_cntr} !== {2'b00, 32'd1}) $display("FAIL run_drop_state busy=%b done=%b avgs=%0d want 0/0/1", busy, done, avgs_cntr);
        else passes++;
    endtask

    task automatic test_zero_limit_and_reset();
        avgs_limit = 32'd0;
        run = 1'b1; trg_flag = 1'b1;
        tv_cnt = 0;
        tick();
        checks++;
        if ({done, busy} !== 2'b10) $display("FAIL zero_limit_done done/busy=%b want 10", {done, busy});
        else passes++;
        trg_flag = 1'b0;
        ticks(5);
        pulse_trg();
        ticks(5);
        checks++;
        if (tv_cnt !== 0) $display("FAIL zero_limit_tvalid got %0d cycles want 0", tv_cnt);
        else passes++;
        run = 1'b0;
        tick();
        // Trigger rising together with run: ignored because the block was still IDLE.
        frame_len = 16'd3; avgs_limit = 32'd2;
        frame_beats = 0;
        run = 1'b1; trg_flag = 1'b1;
        ticks(10);
        checks++;
        if ({frame_beats, busy} !== {32'd0, 1'b1}) $display("FAIL coincident_trg beats=%0d busy=%b want 0/1", frame_beats, busy);
        else passes++;
        trg_flag = 1'b0;
        tick();
        pulse_trg();
        ticks(8);
        checks++;
        if ({frame_beats, avgs_cntr} !== {32'd4, 32'd1}) $display("FAIL rearm_frame beats=%0d avgs=%0d want 4/1", frame_beats, avgs_cntr);
        else passes++;
        frame_beats = 0;
        pulse_trg();
        ticks(2);
        checks++;
        if (m_axis_tvalid !== 1'b1) $display("FAIL pre_reset_gate tvalid=%b want 1", m_axis_tvalid);
        else passes++;
        aresetn = 1'b0; m_axis_tready = 1'b0;
        tick();
        checks++;
        if ({m_axis_tvalid, busy, s_axis_tready, avgs_cntr} !== {3'b001, 32'd0})
            $display("FAIL midframe_reset tvalid=%b busy=%b tready=%b avgs=%0d want 0/0/1/0", m_axis_tvalid, busy, s_axis_tready, avgs_cntr);
        else passes++;
        aresetn = 1'b1;
        tick();
    endtask

    initial begin
        @(posedge aclk);
        #1;
        test_reset();
        test_three_frames();
        test_trigger_held();
        test_stalls();
        test_run_drop();
        test_zero_limit_and_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axis_trigger_frame_gate.md
Name: axis_trigger_frame_gate

Overview:
Triggered frame gate that sits directly upstream of the accumulating averager. It takes a continuous sample stream (ADC or decimator output) and passes exactly frame_len+1 samples after each trigger rising edge. It repeats this until avgs_limit frames have been delivered. Outside a frame, samples are discarded, so the downstream averager sees only whole, trigger-aligned frames.

Parameters:
AXIS_TDATA_WIDTH, 32, sample width, passed through unchanged
CNTR_WIDTH, 16, width of the per-frame sample counter and frame_len
AVGS_WIDTH, 32, width of the frame counter and avgs_limit

Ports:
aclk  input  1  clock
aresetn  input  1  reset; synchronous, active-low
run  input  1  level; rising edge starts an acquisition, low requests stop
trg_flag  input  1  trigger, already synchronous to aclk; rising edge starts a frame
frame_len  input  CNTR_WIDTH  samples per frame minus 1
avgs_limit  input  AVGS_WIDTH  number of frames per acquisition
avgs_cntr  output  AVGS_WIDTH  frames completed in current acquisition
busy  output  1  high in ARMED or GATE
done  output  1  high in DONE
s_axis_tready  output  1  slave ready
s_axis_tdata  input  AXIS_TDATA_WIDTH  sample
s_axis_tvalid  input  1  sample valid
m_axis_tready  input  1  master ready
m_axis_tdata  output  AXIS_TDATA_WIDTH  gated sample
m_axis_tvalid  output  1  gated valid

Behaviour:
- Registers: state, run_q, trg_q (edge detect), frame_len_reg, smp_cntr, avgs_cntr.
- Reset values: state IDLE, run_q/trg_q 0, all counters 0. Outputs: busy 0, done 0, m_axis_tvalid 0, s_axis_tready 1.
- Edge definitions: run_rise = run & ~run_q; trg_rise = trg_flag & ~trg_q. run_q and trg_q update every cycle in every state.
- Datapath is zero-latency, combinational:
  - m_axis_tdata = s_axis_tdata.
  - m_axis_tvalid = s_axis_tvalid & (state==GATE).
  - s_axis_tready = (state==GATE) ? m_axis_tready : 1. Samples are discarded outside GATE.
- xfer = s_axis_tvalid & m_axis_tready & (state==GATE).
- IDLE:
  - On run_rise: avgs_cntr <= 0.
  - If avgs_limit==0, go to DONE (no frames); otherwise go to ARMED.
- ARMED:
  - If run is low, go to IDLE next cycle.
  - Else on trg_rise: frame_len_reg <= frame_len, smp_cntr <= 0, go to GATE.
  - A trigger edge in the same cycle as the IDLE->ARMED transition is ignored (state was not ARMED).
- GATE:
  - Each xfer increments smp_cntr.
  - On xfer with smp_cntr==frame_len_reg: smp_cntr <= 0, avgs_cntr <= avgs_cntr+1. Then:
    - if avgs_cntr+1==avgs_limit, go to DONE;
    - else if run is low, go to IDLE;
    - else go to ARMED.
  - Trigger edges during GATE are ignored, including one coincident with the last sample. The next frame needs a fresh edge seen in ARMED.
  - run falling mid-frame does not truncate: the frame completes, then the block returns to IDLE. Downstream alignment is never broken.
  - Cycles with s_axis_tvalid low or m_axis_tready low do not advance smp_cntr.
- DONE: holds avgs_cntr and done=1 while run is high; run low -> IDLE. The next run_rise restarts.
- Input latching: frame_len is latched per frame, so changes mid-frame have no effect. avgs_limit is compared live, and a value below the current avgs_cntr lets the counter run until it wraps modulo 2^AVGS_WIDTH. Software must not change avgs_limit while busy.
- Counter widths: avgs_cntr wraps modulo 2^AVGS_WIDTH. smp_cntr never exceeds frame_len_reg.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is abandoned.

Test Plan:
- frame_len=7, avgs_limit=3, continuous tvalid, m_tready=1, three trg pulses spaced 20 cycles -> exactly 3 bursts of 8 beats starting the cycle after each edge; avgs_cntr 1,2,3; done=1 after the 24th beat.
- Trigger held high / second edge inside a frame (frame_len=15) -> no restart; 16 beats delivered; the next frame starts only on a new edge in ARMED.
- tvalid toggling 50% plus m_tready stalls, frame_len=4 -> exactly 5 transferred beats per frame; data order identical to input; no beats dropped while in GATE.
- run dropped at beat 3 of a 10-beat frame, avgs_limit=5 -> all 10 beats delivered, then IDLE, avgs_cntr=1, busy=0.
- avgs_limit=0 with run_rise -> DONE next cycle, m_axis_tvalid never asserted; a trg edge coincident with IDLE->ARMED is ignored.
- aresetn low mid-frame -> next cycle: m_axis_tvalid=0, busy=0, avgs_cntr=0, s_axis_tready=1.
